// File: rtl/demultiplexor_16x16_if.sv
// -----------------------------------------------------------------------------
// demultiplexor_16x16_if
//   Bundles the handshake and data signals of the 16-channel demultiplexor.
//
//   Source side (master drives):
//     in[15:0]      data word to distribute
//     sel[3:0]      destination channel when auto = 0
//     auto          1 = destination from internal pointer, 0 = from sel
//     in_valid      in/sel valid this cycle
//     clr           synchronous frame clear
//   Block side (slave drives):
//     in_ready      block accepts a word this cycle
//     out[i]        registered channel data, i = 0..15
//     out_vld       bit i = channel i written since last clear/reset
//     strobe        one-hot, one-cycle pulse marking the channel written
//     frame_done    one-cycle pulse when the frame becomes full
//     ptr[3:0]      current auto-sequence pointer
// -----------------------------------------------------------------------------
interface demultiplexor_16x16_if;
    logic [15:0]        in;
    logic [3:0]         sel;
    logic               auto;
    logic               in_valid;
    logic               in_ready;
    logic               clr;
    logic [15:0][15:0]  out;
    logic [15:0]        out_vld;
    logic [15:0]        strobe;
    logic               frame_done;
    logic [3:0]         ptr;

    modport master (
        output in,
        output sel,
        output auto,
        output in_valid,
        output clr,
        input  in_ready,
        input  out,
        input  out_vld,
        input  strobe,
        input  frame_done,
        input  ptr
    );

    modport slave (
        input  in,
        input  sel,
        input  auto,
        input  in_valid,
        input  clr,
        output in_ready,
        output out,
        output out_vld,
        output strobe,
        output frame_done,
        output ptr
    );
endinterface

// File: rtl/demultiplexor_16x16.sv
// -----------------------------------------------------------------------------
// demultiplexor_16x16
//   Distributes 16-bit words into 16 registered channels. The destination is
//   either sel (manual) or an internal wrapping pointer (auto). Once every
//   channel has been written the frame is full and the block stalls until a
//   synchronous clear.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   demultiplexor_16x16_if.slave (see interface for signal list)
//
//   State table:
//     FILL | at least one channel not yet written; transfers accepted
//     FULL | all 16 channels written; in_ready low until clr
// -----------------------------------------------------------------------------
module demultiplexor_16x16 (
    input  logic                   clk,
    input  logic                   rst,
    demultiplexor_16x16_if.slave   bus
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [15:0][15:0]  out_q;
    logic [15:0]        vld_q;
    logic [15:0]        strobe_q;
    logic               frame_done_q;
    logic [3:0]         ptr_q;

    logic               ready;
    logic               xfer;
    logic [3:0]         dest;
    logic [15:0]        dest_hot;
    logic               frame_complete;

    // Transfer qualification and destination decode
    always_comb begin
        dest           = bus.auto ? ptr_q : bus.sel;
        dest_hot       = 16'h0001 << dest;
        xfer           = bus.in_valid && ready;
        // The write that fills the last empty channel completes the frame
        frame_complete = xfer && ((vld_q | dest_hot) == 16'hFFFF);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clr dominates everything
    always_comb begin
        state_next = state;
        if (bus.clr) begin
            state_next = FILL;
        end else begin
            case (state)
                FILL:    if (frame_complete) state_next = FULL;
                FULL:    state_next = FULL;
                default: state_next = FILL;
            endcase
        end
    end

    // Output logic: ready is combinational from state and clr
    always_comb begin
        ready = (state == FILL) && !bus.clr;
    end

    // Channel data registers; clr leaves the data untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else if (xfer) begin
            out_q[dest] <= bus.in;
        end
    end

    // Valid bits, strobe, frame pulse and pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q        <= 16'h0000;
            strobe_q     <= 16'h0000;
            frame_done_q <= 1'b0;
            ptr_q        <= 4'd0;
        end else if (bus.clr) begin
            vld_q        <= 16'h0000;
            strobe_q     <= 16'h0000;
            frame_done_q <= 1'b0;
            ptr_q        <= 4'd0;
        end else begin
            strobe_q     <= xfer ? dest_hot : 16'h0000;
            frame_done_q <= frame_complete;
            if (xfer) begin
                vld_q <= vld_q | dest_hot;
                // A manual write leaves the auto sequence where it was
                if (bus.auto) begin
                    ptr_q <= ptr_q + 4'd1;
                end
            end
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out        = out_q;
    assign bus.out_vld    = vld_q;
    assign bus.strobe     = strobe_q;
    assign bus.frame_done = frame_done_q;
    assign bus.ptr        = ptr_q;

endmodule

// File: doc/demultiplexor_16x16.md
DEMULTIPLEXOR_16X16 -- requirements
Module: demultiplexor_16x16

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 IN  input  16  data word to distribute.
REQ-005 SEL  input  4  destination channel, used when AUTO=0.
REQ-006 AUTO  input  1  1 = destination taken from internal pointer PTR; 0 = from SEL.
REQ-007 IN_VALID  input  1  IN/SEL valid this cycle.
REQ-008 IN_READY  output  1  block accepts a word this cycle.
REQ-009 CLR  input  1  synchronous frame clear.
REQ-010 OUT0..OUT15  output  16 each  registered channel data.
REQ-011 OUT_VLD  output  16  bit i = OUTi written since last clear/reset.
REQ-012 STROBE  output  16  one-hot, one-cycle pulse marking the channel written.
REQ-013 FRAME_DONE  output  1  one-cycle pulse when the frame becomes full.
REQ-014 PTR  output  4  current auto-sequence pointer.

Function
REQ-015 Transfer occurs on a rising edge where IN_VALID=1 and IN_READY=1.
REQ-016 Destination index D = PTR when AUTO=1, else SEL; sampled in the transfer cycle.
REQ-017 On transfer, OUT[D] <= IN; all other OUTi hold.
REQ-018 On transfer, OUT_VLD[D] <= 1; overwriting an already-valid channel is allowed and leaves its bit set.
REQ-019 STROBE is registered: equals one-hot(D) in the cycle after a transfer, 0 otherwise.
REQ-020 Latency: new OUT[D], OUT_VLD[D] and STROBE[D] are all visible in the first cycle after the transfer edge.
REQ-021 PTR increments by 1 on each transfer with AUTO=1, wrapping 15 -> 0; holds when AUTO=0 or no transfer.
REQ-022 State machine has two states: FILL (OUT_VLD != 16'hFFFF) and FULL (OUT_VLD == 16'hFFFF).
REQ-023 FILL -> FULL on the transfer that sets the last zero bit of OUT_VLD; FULL -> FILL only on CLR.
REQ-024 FRAME_DONE = 1 for exactly the first cycle in FULL (aligned with STROBE of the completing write); 0 otherwise.
REQ-025 IN_READY = 1 in FILL with CLR=0; IN_READY = 0 in FULL or whenever CLR=1 (combinational from state and CLR).
REQ-026 CLR=1 at an edge: OUT_VLD <= 0, PTR <= 0, state <= FILL, STROBE <= 0, FRAME_DONE <= 0; OUT0..OUT15 retain data.
REQ-027 CLR and IN_VALID in the same cycle: CLR wins, no transfer, PTR not incremented.
REQ-028 AUTO may change between transfers; a manual write does not move PTR, so the auto sequence resumes at the unchanged PTR.
REQ-029 IN_VALID while IN_READY=0 has no effect; the source holds IN/SEL until accepted.

Reset
REQ-030 RST=1 immediately (no clock edge required) forces OUT0..OUT15=16'h0000, OUT_VLD=16'h0000, STROBE=16'h0000, FRAME_DONE=0, PTR=0, state=FILL.
REQ-031 IN_READY=1 while RST=1 and CLR=0 (FILL state), but no transfer occurs until RST deasserts.
REQ-032 RST asserted mid-frame discards all progress; the first transfer after release writes channel 0 in AUTO mode.

Verification
REQ-033 Reset: assert RST between edges -> all OUTi, OUT_VLD, PTR read 0 before the next edge.
REQ-034 Manual: AUTO=0, SEL=4'hA, IN=16'hBEEF, one transfer -> OUT10=16'hBEEF, OUT_VLD=16'h0400, STROBE=16'h0400 for one cycle, PTR=0.
REQ-035 Auto frame: AUTO=1, 16 back-to-back transfers IN=16'h0000..16'h000F -> OUTi=i, PTR wraps to 0, FRAME_DONE one pulse aligned with STROBE=16'h8000, IN_READY=0 afterwards.
REQ-036 Backpressure: in FULL hold IN_VALID=1, IN=16'h1234 for 5 cycles -> no OUTi changes, no STROBE; then CLR -> OUT_VLD=0, IN_READY=1 next cycle, data retained.
REQ-037 Collision: CLR=1 and IN_VALID=1 same cycle with PTR=5 -> no write, PTR=0, OUT_VLD=0.
REQ-038 Overwrite/mixed: AUTO=0 write channel 3 twice (16'h1111 then 16'h2222) -> OUT3=16'h2222, OUT_VLD=16'h0008, no FRAME_DONE; switch AUTO=1 -> next write lands on channel 0.
